// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin front end for a shared 8-bit signed ALU with a held response port.
// Optional macro ALU_SHARE_SAT_EN: clamp overflowing ADD/SUB results instead of wrapping.
module alu_share_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_a0,
    input  logic [7:0] req_b0,
    input  logic [7:0] req_a1,
    input  logic [7:0] req_b1,
    input  logic [1:0] req_f0,
    input  logic [1:0] req_f1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_ovf,
    output logic [7:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_r;
    logic       prio_r;
    logic [7:0] op_a_r;
    logic [7:0] op_b_r;
    logic [1:0] op_f_r;
    logic       op_id_r;
    logic       rsp_valid_r;
    logic       rsp_id_r;
    logic [7:0] rsp_data_r;
    logic       rsp_ovf_r;
    logic [7:0] ops_done_r;
    logic [1:0] grant_s;
    logic [8:0] alu_s;

    // Returns {ovf, result}; ADD/SUB overflow is judged on the wrapped result.
    function automatic logic [8:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] f);
        logic [7:0] res;
        logic       ovf;
        case (f)
            2'b00: begin
                res = a & b;
                ovf = 1'b0;
            end
            2'b01: begin
                res = a | b;
                ovf = 1'b0;
            end
            2'b10: begin
                res = a + b;
                ovf = (a[7] == b[7]) && (res[7] != a[7]);
            end
            2'b11: begin
                res = a - b;
                ovf = (a[7] != b[7]) && (res[7] != a[7]);
            end
            default: begin
                res = 8'h00;
                ovf = 1'b0;
            end
        endcase
`ifdef ALU_SHARE_SAT_EN
        if (ovf) begin
            res = a[7] ? 8'h80 : 8'h7F;
        end else begin
            res = res;
        end
`endif
        return {ovf, res};
    endfunction

    // Round-robin grant, only offered while idle; prio_r names the requester that wins a tie.
    always_comb begin
        grant_s = 2'b00;
        if (state_r == IDLE) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = prio_r ? 2'b10 : 2'b01;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign alu_s = alu_eval(op_a_r, op_b_r, op_f_r);

    // Controller FSM: grant and latch, evaluate into the response registers, then hold until accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            prio_r      <= 1'b0;
            op_a_r      <= 8'h00;
            op_b_r      <= 8'h00;
            op_f_r      <= 2'b00;
            op_id_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_ovf_r   <= 1'b0;
            ops_done_r  <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        op_id_r <= grant_s[1];
                        op_a_r  <= grant_s[1] ? req_a1 : req_a0;
                        op_b_r  <= grant_s[1] ? req_b1 : req_b0;
                        op_f_r  <= grant_s[1] ? req_f1 : req_f0;
                        prio_r  <= ~grant_s[1];
                        state_r <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_r  <= alu_s[7:0];
                    rsp_ovf_r   <= alu_s[8];
                    rsp_id_r    <= op_id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ops_done_r  <= ops_done_r + 8'd1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_ovf   = rsp_ovf_r;
    assign ops_done  = ops_done_r;

endmodule
